lsu_stage: RTL and testbench

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage.sv | 190 +++++++++++++++++++
 tb/tb_lsu_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_stage
// Brief    : RV32I load/store unit. It accepts one memory op from EX, checks
//            alignment, issues a single-beat request on the data bus, aligns
//            and extends load data for writeback, and reports a bus error
//            when the grant or the response does not arrive in time.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_is_load_i,
  input  logic        ex_is_store_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        exc_misaligned_o,
  output logic        exc_buserr_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  // The wait counter runs from 0; the last allowed cycle is TIMEOUT-1.
  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_exc_mis;
  logic        r_exc_bus;

  logic        w_xfer;
  logic        w_aligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rdata_sh;
  logic [31:0] w_load_ext;

  assign w_xfer     = ex_valid_i & (r_state == IDLE) & (ex_is_load_i | ex_is_store_i);
  assign w_wdata_sh = ex_wdata_i << {ex_addr_i[1:0], 3'b000};
  assign w_rdata_sh = mem_rdata_i >> {r_addr[1:0], 3'b000};

  // Decode access width into byte enables and alignment legality.
  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    case (ex_funct3_i)
      3'b000, 3'b100: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << ex_addr_i[1:0];
      end
      3'b001, 3'b101: begin
        w_aligned = ~ex_addr_i[0];
        w_be      = 4'b0011 << ex_addr_i[1:0];
      end
      3'b010: begin
        w_aligned = (ex_addr_i[1:0] == 2'b00);
        w_be      = 4'b1111;
      end
      default: begin
        w_aligned = 1'b0;  // reserved widths are reported as misaligned
        w_be      = 4'b0000;
      end
    endcase
  end

  // Sign- or zero-extend the lane-aligned read data.
  always_comb begin
    w_load_ext = w_rdata_sh;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_rdata_sh[7]}}, w_rdata_sh[7:0]};
      3'b100:  w_load_ext = {24'h000000, w_rdata_sh[7:0]};
      3'b001:  w_load_ext = {{16{w_rdata_sh[15]}}, w_rdata_sh[15:0]};
      3'b101:  w_load_ext = {16'h0000, w_rdata_sh[15:0]};
      default: w_load_ext = w_rdata_sh;
    endcase
  end

  // Transaction FSM with wait counter and registered pulse outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_addr     <= 32'd0;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_rd       <= 5'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
      r_exc_mis  <= 1'b0;
      r_exc_bus  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_exc_mis  <= 1'b0;
      r_exc_bus  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (!w_aligned) begin
              r_exc_mis <= 1'b1;
            end else begin
              r_addr   <= ex_addr_i;
              r_we     <= ex_is_store_i;
              r_funct3 <= ex_funct3_i;
              r_rd     <= ex_rd_i;
              r_be     <= w_be;
              r_wdata  <= w_wdata_sh;
              r_cnt    <= 8'd0;
              r_state  <= REQ;
            end
          end
        end
        REQ: begin
          // A response in the grant cycle is not looked at here.
          if (mem_gnt_i) begin
            r_cnt   <= 8'd0;
            r_state <= r_we ? IDLE : WAIT_R;
          end else if (r_cnt == C_CNT_LAST) begin
            r_exc_bus <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        WAIT_R: begin
          if (mem_rvalid_i) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_ext;
            r_state    <= IDLE;
          end else if (r_cnt == C_CNT_LAST) begin
            r_exc_bus <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ex_ready_o       = (r_state == IDLE);
  assign busy_o           = (r_state != IDLE);
  assign mem_req_o        = (r_state == REQ);
  assign mem_we_o         = r_we;
  assign mem_addr_o       = {r_addr[31:2], 2'b00};
  assign mem_be_o         = r_be;
  assign mem_wdata_o      = r_wdata;
  assign wb_valid_o       = r_wb_valid;
  assign wb_rd_o          = r_wb_rd;
  assign wb_data_o        = r_wb_data;
  assign exc_misaligned_o = r_exc_mis;
  assign exc_buserr_o     = r_exc_bus;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_stage
// Brief    : Directed bench for lsu_stage: loads, stores, alignment faults,
//            grant/response timeouts and mid-transaction reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_mis;
  logic        exc_bus;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  lsu_stage #(.TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_is_load_i(ex_is_load), .ex_is_store_i(ex_is_store),
    .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr),
    .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .exc_misaligned_o(exc_mis), .exc_buserr_o(exc_bus), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle, then withdraw it.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    tick();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  // Load with immediate grant and response one cycle later.
  task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
    issue(1'b1, 1'b0, f3, a, 32'd0, 5'd9);
    chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_data"}, wb_data, exp_data);
  endtask

  initial begin
    logic seen;

    // Reset state
    #1;
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // LW 0x100: grant one cycle after request, response two cycles after grant
    chk("lw_ready_idle", {31'd0, ex_ready}, 32'd1);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd5);
    chk("lw_req", {31'd0, mem_req}, 32'd1);
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_be", {28'd0, mem_be}, 32'hF);
    chk("lw_we", {31'd0, mem_we}, 32'd0);
    chk("lw_ready0", {31'd0, ex_ready}, 32'd0);
    tick();
    chk("lw_req_hold", {31'd0, mem_req}, 32'd1);
    chk("lw_addr_hold", mem_addr, 32'h100);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("lw_wait_noreq", {31'd0, mem_req}, 32'd0);
    chk("lw_ready1", {31'd0, ex_ready}, 32'd0);
    tick();
    chk("lw_ready2", {31'd0, ex_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("lw_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lw_data", wb_data, 32'hDEADBEEF);
    chk("lw_rd", {27'd0, wb_rd}, 32'd5);
    tick();
    chk("lw_wbv_pulse", {31'd0, wb_valid}, 32'd0);

    // Byte/half loads with sign and zero extension
    quick_load("lb", 3'b000, 32'h103, 32'h80123456, 4'b1000, 32'hFFFFFF80);
    quick_load("lbu", 3'b100, 32'h103, 32'h80123456, 4'b1000, 32'h00000080);
    quick_load("lh", 3'b001, 32'h102, 32'h80123456, 4'b1100, 32'hFFFF8012);
    quick_load("lhu", 3'b101, 32'h102, 32'h80123456, 4'b1100, 32'h00008012);
    quick_load("lb0", 3'b000, 32'h100, 32'h0000007F, 4'b0001, 32'h0000007F);

    // SH 0x202
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0);
    chk("sh_addr", mem_addr, 32'h200);
    chk("sh_be", {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCD0000);
    chk("sh_we", {31'd0, mem_we}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sh_idle", {31'd0, ex_ready}, 32'd1);
    chk("sh_nowb", {31'd0, wb_valid}, 32'd0);

    // SB 0x201
    issue(1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 5'd0);
    chk("sb_be", {28'd0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'h34567800);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;

    // Misaligned LW 0x101
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 5'd1);
    chk("mis_exc", {31'd0, exc_mis}, 32'd1);
    chk("mis_noreq", {31'd0, mem_req}, 32'd0);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("mis_pulse", {31'd0, exc_mis}, 32'd0);
    chk("mis_noreq2", {31'd0, mem_req}, 32'd0);

    // Misaligned halfword and reserved width
    issue(1'b1, 1'b0, 3'b101, 32'h103, 32'd0, 5'd1);
    chk("mis_hu", {31'd0, exc_mis}, 32'd1);
    issue(1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 5'd1);
    chk("mis_f3_011", {31'd0, exc_mis}, 32'd1);
    chk("mis_f3_busy", {31'd0, busy}, 32'd0);

    // Valid without load/store is ignored
    issue(1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 5'd1);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_exc", {31'd0, exc_mis}, 32'd0);

    // Grant withheld: bus error 16 cycles after REQ entry; stray rvalid ignored
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd2);
    seen = 1'b0;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 2) mem_rvalid = 1'b0;
      seen = seen | exc_bus | wb_valid;
    end
    chk("to_gnt_early", {31'd0, seen}, 32'd0);
    chk("to_gnt_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("to_gnt_exc", {31'd0, exc_bus}, 32'd1);
    chk("to_gnt_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("to_gnt_pulse", {31'd0, exc_bus}, 32'd0);

    // Response in grant cycle ignored; WAIT_R then times out
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd3);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | exc_bus | wb_valid;
    end
    chk("to_rv_early", {31'd0, seen}, 32'd0);
    tick();
    chk("to_rv_exc", {31'd0, exc_bus}, 32'd1);
    chk("to_rv_nowb", {31'd0, wb_valid}, 32'd0);
    chk("to_rv_idle", {31'd0, busy}, 32'd0);

    // Reset during WAIT_R, then a late response
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd4);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rstw_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_async_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    tick();
    mem_rvalid = 1'b0;
    chk("rstw_nowb", {31'd0, wb_valid}, 32'd0);
    chk("rstw_noexc", {30'd0, exc_bus, exc_mis}, 32'd0);
    chk("rstw_idle", {31'd0, busy}, 32'd0);
    chk("rstw_ready", {31'd0, ex_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
